// File: rtl/cpu_axi_lite_bridge.sv
// CPU load/store to AXI4-Lite master bridge with independent read and write channels.
// Optional dead-slave watchdog per channel enabled by defining CPU_AXI_TIMEOUT_EN.
module cpu_axi_lite_bridge #(
   parameter int unsigned ADDR_W      = 64,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   // CPU read port
   input  logic                  r_req,
   input  logic [ADDR_W-1:0]     r_addr,
   output logic                  r_busy,
   output logic                  r_data_valid,
   output logic [DATA_W-1:0]     r_data,
   output logic [1:0]            r_err,
   // CPU write port
   input  logic                  w_req,
   input  logic [ADDR_W-1:0]     w_addr,
   input  logic [DATA_W-1:0]     w_data,
   input  logic [DATA_W/8-1:0]   w_strb,
   output logic                  w_busy,
   output logic                  w_done,
   output logic [1:0]            w_err,
   // AXI4-Lite master
   output logic                  aclk,
   output logic                  aresetn,
   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_W-1:0]     m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int unsigned STRB_W = DATA_W / 8;
`ifdef CPU_AXI_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
`endif

   typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
   typedef enum logic [1:0] {WR_IDLE, WR_ADDR_DATA, WR_RESP} wr_state_e;

   // ---------------- read channel state ----------------
   rd_state_e             rd_state_q, rd_state_d;
   logic [ADDR_W-1:0]     araddr_q, araddr_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic                  r_busy_q, r_busy_d;
   logic                  r_data_valid_q, r_data_valid_d;
   logic [DATA_W-1:0]     r_data_q, r_data_d;
   logic [1:0]            r_err_q, r_err_d;

   // ---------------- write channel state ----------------
   wr_state_e             wr_state_q, wr_state_d;
   logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  aw_ok_q, aw_ok_d;
   logic                  w_ok_q, w_ok_d;
   logic                  bready_q, bready_d;
   logic                  w_busy_q, w_busy_d;
   logic                  w_done_q, w_done_d;
   logic [1:0]            w_err_q, w_err_d;

`ifdef CPU_AXI_TIMEOUT_EN
   logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
`endif

   // Read FSM next-state and registered outputs
   always_comb begin
      rd_state_d     = rd_state_q;
      araddr_d       = araddr_q;
      arvalid_d      = arvalid_q;
      rready_d       = rready_q;
      r_data_valid_d = 1'b0;
      r_data_d       = r_data_q;
      r_err_d        = r_err_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (r_req) begin
               araddr_d   = r_addr;
               arvalid_d  = 1'b1;
               rd_state_d = RD_AR;
            end
         end
         RD_AR: begin
            if (m_axi_arready) begin
               arvalid_d  = 1'b0;
               rready_d   = 1'b1;
               rd_state_d = RD_R;
            end
         end
         RD_R: begin
            if (m_axi_rvalid) begin
               rready_d       = 1'b0;
               r_data_d       = m_axi_rdata;
               r_err_d        = m_axi_rresp;
               r_data_valid_d = 1'b1;
               rd_state_d     = RD_IDLE;
            end
         end
         default: begin
            rd_state_d = RD_IDLE;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
         end
      endcase
`ifdef CPU_AXI_TIMEOUT_EN
      rd_cnt_d = (rd_state_q == RD_IDLE) ? '0 : CNT_W'(rd_cnt_q + 1'b1);
      // Dead-slave escape: abandon the transaction and report 2'b11
      if ((rd_state_q != RD_IDLE) && (rd_cnt_q >= CNT_W'(TIMEOUT_CYC - 1))) begin
         rd_state_d     = RD_IDLE;
         arvalid_d      = 1'b0;
         rready_d       = 1'b0;
         r_data_d       = '0;
         r_err_d        = 2'b11;
         r_data_valid_d = 1'b1;
         rd_cnt_d       = '0;
      end
`endif
      r_busy_d = (rd_state_d != RD_IDLE);
   end

   // Write FSM next-state and registered outputs
   always_comb begin
      wr_state_d = wr_state_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      aw_ok_d    = aw_ok_q;
      w_ok_d     = w_ok_q;
      bready_d   = bready_q;
      w_done_d   = 1'b0;
      w_err_d    = w_err_q;
      case (wr_state_q)
         WR_IDLE: begin
            if (w_req) begin
               awaddr_d   = w_addr;
               wdata_d    = w_data;
               wstrb_d    = w_strb;
               awvalid_d  = 1'b1;
               wvalid_d   = 1'b1;
               aw_ok_d    = 1'b0;
               w_ok_d     = 1'b0;
               wr_state_d = WR_ADDR_DATA;
            end
         end
         WR_ADDR_DATA: begin
            // AW and W complete independently; sticky flags remember each handshake
            aw_ok_d   = aw_ok_q | (awvalid_q & m_axi_awready);
            w_ok_d    = w_ok_q | (wvalid_q & m_axi_wready);
            awvalid_d = ~aw_ok_d;
            wvalid_d  = ~w_ok_d;
            if (aw_ok_d && w_ok_d) begin
               bready_d   = 1'b1;
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (m_axi_bvalid) begin
               bready_d   = 1'b0;
               w_err_d    = m_axi_bresp;
               w_done_d   = 1'b1;
               wr_state_d = WR_IDLE;
            end
         end
         default: begin
            wr_state_d = WR_IDLE;
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
         end
      endcase
`ifdef CPU_AXI_TIMEOUT_EN
      wr_cnt_d = (wr_state_q == WR_IDLE) ? '0 : CNT_W'(wr_cnt_q + 1'b1);
      if ((wr_state_q != WR_IDLE) && (wr_cnt_q >= CNT_W'(TIMEOUT_CYC - 1))) begin
         wr_state_d = WR_IDLE;
         awvalid_d  = 1'b0;
         wvalid_d   = 1'b0;
         bready_d   = 1'b0;
         w_err_d    = 2'b11;
         w_done_d   = 1'b1;
         wr_cnt_d   = '0;
      end
`endif
      w_busy_d = (wr_state_d != WR_IDLE);
   end

   // Read channel registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state_q     <= RD_IDLE;
         araddr_q       <= '0;
         arvalid_q      <= 1'b0;
         rready_q       <= 1'b0;
         r_busy_q       <= 1'b0;
         r_data_valid_q <= 1'b0;
         r_data_q       <= '0;
         r_err_q        <= 2'b00;
      end else begin
         rd_state_q     <= rd_state_d;
         araddr_q       <= araddr_d;
         arvalid_q      <= arvalid_d;
         rready_q       <= rready_d;
         r_busy_q       <= r_busy_d;
         r_data_valid_q <= r_data_valid_d;
         r_data_q       <= r_data_d;
         r_err_q        <= r_err_d;
      end
   end

   // Write channel registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_state_q <= WR_IDLE;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         aw_ok_q    <= 1'b0;
         w_ok_q     <= 1'b0;
         bready_q   <= 1'b0;
         w_busy_q   <= 1'b0;
         w_done_q   <= 1'b0;
         w_err_q    <= 2'b00;
      end else begin
         wr_state_q <= wr_state_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         aw_ok_q    <= aw_ok_d;
         w_ok_q     <= w_ok_d;
         bready_q   <= bready_d;
         w_busy_q   <= w_busy_d;
         w_done_q   <= w_done_d;
         w_err_q    <= w_err_d;
      end
   end

`ifdef CPU_AXI_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end
`endif

   assign aclk          = clk;
   assign aresetn       = ~reset;

   assign r_busy        = r_busy_q;
   assign r_data_valid  = r_data_valid_q;
   assign r_data        = r_data_q;
   assign r_err         = r_err_q;
   assign w_busy        = w_busy_q;
   assign w_done        = w_done_q;
   assign w_err         = w_err_q;

   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_cpu_axi_lite_bridge.sv
// Directed bench for cpu_axi_lite_bridge: AXI slave model plus scoreboard queues,
// all driven from one linear initial block stepping on the falling clock edge.
module tb_cpu_axi_lite_bridge;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned TO_CYC = 16;

   logic              clk, reset;
   logic              r_req, r_busy, r_data_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_err;
   logic              w_req, w_busy, w_done;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   logic [1:0]        w_err;
   logic              aclk, aresetn;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic [2:0]        awprot, arprot;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   logic [DATA_W-1:0] wdata, rdata;
   logic [STRB_W-1:0] wstrb;
   logic [1:0]        bresp, rresp;

   cpu_axi_lite_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .reset(reset),
      .r_req(r_req), .r_addr(r_addr), .r_busy(r_busy), .r_data_valid(r_data_valid),
      .r_data(r_data), .r_err(r_err),
      .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_strb(w_strb),
      .w_busy(w_busy), .w_done(w_done), .w_err(w_err),
      .aclk(aclk), .aresetn(aresetn),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      int                t0;
      int                lat;
   } rd_exp_t;

   rd_exp_t           rd_exp_q[$];
   logic [ADDR_W-1:0] ar_addr_q[$];
   logic [ADDR_W-1:0] aw_addr_q[$];
   logic [DATA_W-1:0] w_data_q[$];
   logic [STRB_W-1:0] w_strb_q[$];
   logic [1:0]        wr_resp_q[$];

   int errors, checks, cyc;
   // slave model configuration and state
   int ar_lat, r_lat, aw_lat, w_lat, b_lat;
   logic [DATA_W-1:0] rd_data_cfg;
   logic [1:0]        rd_resp_cfg, b_resp_cfg;
   int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   logic r_pend, b_pend, aw_seen, w_seen;
   logic ar_fire, r_fire, aw_fire, w_fire, b_fire;
   logic prev_rdv, prev_wd;
   int n_ar, n_r, n_aw, n_w, n_b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      rd_exp_q.delete(); ar_addr_q.delete(); aw_addr_q.delete();
      w_data_q.delete(); w_strb_q.delete(); wr_resp_q.delete();
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      rdata = '0; rresp = 0; bresp = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
      ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
      prev_rdv = 0; prev_wd = 0;
   endtask

   // One clock: observe DUT at the falling edge, score it, then drive the slave side
   task automatic step();
      rd_exp_t e;
      @(negedge clk);
      cyc++;
      if (ar_fire) begin r_pend = 1; r_cnt = 0; end
      if (r_fire) begin r_pend = 0; rvalid = 0; end
      if (b_fire) begin bvalid = 0; b_pend = 0; aw_seen = 0; w_seen = 0; end
      if (aw_fire || w_fire) begin
         if (aw_fire) aw_seen = 1;
         if (w_fire) w_seen = 1;
         if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; end
      end
      // CPU-side completions
      if (r_data_valid) begin
         if (rd_exp_q.size() == 0) check("r_unexpected_valid", 64'(r_data_valid), 0);
         else begin
            e = rd_exp_q.pop_front();
            check("r_data", 64'(r_data), 64'(e.data));
            check("r_err", 64'(r_err), 64'(e.resp));
            check("r_busy_at_valid", 64'(r_busy), 0);
            if (e.lat != 0) check("r_latency", 64'(cyc - e.t0), 64'(e.lat));
         end
      end
      if (prev_rdv) check("r_valid_width", 64'(r_data_valid), 0);
      prev_rdv = r_data_valid;
      if (w_done) begin
         if (wr_resp_q.size() == 0) check("w_unexpected_done", 64'(w_done), 0);
         else begin
            check("w_err", 64'(w_err), 64'(wr_resp_q.pop_front()));
            check("w_busy_at_done", 64'(w_busy), 0);
         end
      end
      if (prev_wd) check("w_done_width", 64'(w_done), 0);
      prev_wd = w_done;
      if (w_seen && !aw_seen) check("wvalid_drop_awvalid_hold", {62'd0, wvalid, awvalid}, 64'b01);
      if (bready) check("bready_after_both", {62'd0, aw_seen, w_seen}, 64'b11);
      // AR
      if (arvalid) begin
         if (ar_cnt >= ar_lat) arready = 1; else begin arready = 0; ar_cnt++; end
      end else begin arready = 0; ar_cnt = 0; end
      ar_fire = arvalid && arready;
      if (ar_fire) begin
         n_ar++; ar_cnt = 0;
         check("arprot", 64'(arprot), 0);
         if (ar_addr_q.size() == 0) check("ar_unexpected", 64'(araddr), 64'hFFFF_FFFF_FFFF_FFFF);
         else check("araddr", araddr, ar_addr_q.pop_front());
      end
      // R
      if (r_pend && !rvalid) begin
         if (r_cnt >= r_lat) begin rvalid = 1; rdata = rd_data_cfg; rresp = rd_resp_cfg; end
         else r_cnt++;
      end
      r_fire = rvalid && rready;
      if (r_fire) n_r++;
      // AW / W
      if (awvalid && !aw_seen) begin
         if (aw_cnt >= aw_lat) awready = 1; else begin awready = 0; aw_cnt++; end
      end else begin awready = 0; aw_cnt = 0; end
      aw_fire = awvalid && awready;
      if (aw_fire) begin
         n_aw++;
         if (aw_addr_q.size() == 0) check("aw_unexpected", 64'(awaddr), 64'hFFFF_FFFF_FFFF_FFFF);
         else check("awaddr", awaddr, aw_addr_q.pop_front());
      end
      if (wvalid && !w_seen) begin
         if (w_cnt >= w_lat) wready = 1; else begin wready = 0; w_cnt++; end
      end else begin wready = 0; w_cnt = 0; end
      w_fire = wvalid && wready;
      if (w_fire) begin
         n_w++;
         if (w_data_q.size() == 0) check("w_unexpected", 64'(wdata), 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            check("wdata", 64'(wdata), 64'(w_data_q.pop_front()));
            check("wstrb", 64'(wstrb), 64'(w_strb_q.pop_front()));
         end
      end
      // B
      if (b_pend && !bvalid) begin
         if (b_cnt >= b_lat) begin bvalid = 1; bresp = b_resp_cfg; end
         else b_cnt++;
      end
      b_fire = bvalid && bready;
      if (b_fire) n_b++;
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [1:0] resp, input int lat);
      rd_exp_t e;
      r_addr = a; r_req = 1;
      rd_data_cfg = d; rd_resp_cfg = resp;
      e.data = d; e.resp = resp; e.t0 = cyc; e.lat = lat;
      rd_exp_q.push_back(e);
      ar_addr_q.push_back(a);
      step();
      r_req = 0; r_addr = ~a;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [STRB_W-1:0] s, input logic [1:0] resp);
      w_addr = a; w_data = d; w_strb = s; w_req = 1;
      b_resp_cfg = resp;
      aw_addr_q.push_back(a); w_data_q.push_back(d); w_strb_q.push_back(s);
      wr_resp_q.push_back(resp);
      step();
      w_req = 0; w_addr = ~a; w_data = ~d; w_strb = ~s;
   endtask

   task automatic wait_quiet(input int max_cyc);
      int n;
      n = 0;
      while ((r_busy || w_busy || rd_exp_q.size() != 0 || wr_resp_q.size() != 0) && n < max_cyc) begin
         step(); n++;
      end
      check("quiet", {60'd0, r_busy, w_busy, rd_exp_q.size() != 0, wr_resp_q.size() != 0}, 0);
   endtask

   initial begin
      int ar0, aw0, found;
      errors = 0; checks = 0; cyc = 0;
      n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
      ar_lat = 0; r_lat = 0; aw_lat = 0; w_lat = 0; b_lat = 0;
      rd_data_cfg = '0; rd_resp_cfg = 0; b_resp_cfg = 0;
      r_req = 0; r_addr = '0; w_req = 0; w_addr = '0; w_data = '0; w_strb = '0;
      clear_model();
      reset = 1;
      step(); step();
      check("reset_ctrl", {55'd0, arvalid, rready, awvalid, wvalid, bready,
                           r_busy, w_busy, r_data_valid, w_done}, 0);
      check("reset_regs", {28'd0, r_data, r_err, w_err}, 0);
      check("reset_aresetn", 64'(aresetn), 0);
      reset = 0;
      step();
      check("aresetn_high", 64'(aresetn), 1);

      // read, arready zero-wait, rvalid two cycles later
      ar_lat = 0; r_lat = 2;
      rd(64'h1000, 32'hDEAD_BEEF, 2'b00, 5);
      wait_quiet(40);
      // fully zero-wait read: minimum latency
      r_lat = 0;
      rd(64'h0000_0001_0000_1008, 32'hCAFE_F00D, 2'b00, 3);
      wait_quiet(40);

      // write: W handshake three cycles before AW
      aw_lat = 3; w_lat = 0; b_lat = 1;
      wr(64'h2000, 32'h1234_5678, 4'b0011, 2'b00);
      wait_quiet(40);
      // both handshakes in the same cycle
      aw_lat = 0; w_lat = 0; b_lat = 0;
      wr(64'h2004, 32'hA5A5_5A5A, 4'b1111, 2'b00);
      wait_quiet(40);
      // AW before W
      aw_lat = 0; w_lat = 4; b_lat = 2;
      wr(64'h2008, 32'h0F0F_F0F0, 4'b1100, 2'b01);
      wait_quiet(40);

      // concurrent error responses, no retries
      ar0 = n_ar; aw0 = n_aw;
      ar_lat = 1; r_lat = 3; aw_lat = 1; w_lat = 2; b_lat = 2;
      w_addr = 64'h5000; w_data = 32'h7777_8888; w_strb = 4'b1010; w_req = 1;
      b_resp_cfg = 2'b10;
      aw_addr_q.push_back(64'h5000); w_data_q.push_back(32'h7777_8888);
      w_strb_q.push_back(4'b1010); wr_resp_q.push_back(2'b10);
      rd(64'h6000, 32'h0BAD_0BAD, 2'b11, 0);
      w_req = 0;
      wait_quiet(60);
      repeat (5) step();
      check("no_retry_ar", 64'(n_ar - ar0), 1);
      check("no_retry_aw", 64'(n_aw - aw0), 1);
      check("bus_totals", {n_r, n_b}, {32'(n_ar), 32'(n_aw)});

      // request while busy is dropped; request in the valid cycle is taken
      ar0 = n_ar;
      ar_lat = 2; r_lat = 2;
      rd(64'h3000, 32'h1111_2222, 2'b00, 0);
      r_addr = 64'h3100; r_req = 1;
      step();
      r_req = 0;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         step();
         if (r_data_valid) found = 1;
      end
      check("b2b_valid_seen", 64'(found), 1);
      ar_lat = 0; r_lat = 0;
      rd(64'h3200, 32'h3333_4444, 2'b01, 3);
      check("arvalid_after_b2b_req", 64'(arvalid), 1);
      wait_quiet(40);
      check("no_ar_while_busy", 64'(n_ar - ar0), 2);

      // asynchronous reset in the middle of a write
      aw_lat = 100; w_lat = 100;
      wr(64'h4000, 32'hFACE_FACE, 4'b1111, 2'b00);
      check("awvalid_before_reset", 64'(awvalid), 1);
      #2 reset = 1;
      #1;
      check("async_reset_ctrl", {55'd0, arvalid, rready, awvalid, wvalid, bready,
                                 r_busy, w_busy, r_data_valid, w_done}, 0);
      check("async_reset_regs", {28'd0, r_data, r_err, w_err}, 0);
      check("async_reset_aresetn", 64'(aresetn), 0);
      clear_model();
      step(); step();
      reset = 0;
      aw0 = n_aw;
      aw_lat = 1; w_lat = 1; b_lat = 1;
      wr(64'h4100, 32'h0123_4567, 4'b0110, 2'b00);
      wait_quiet(40);
      check("post_reset_write_aw", 64'(n_aw - aw0), 1);

`ifdef CPU_AXI_TIMEOUT_EN
      // dead slave on AR: watchdog abandons the read
      ar_lat = 1000;
      rd(64'h7000, 32'h0000_0000, 2'b11, TO_CYC + 1);
      wait_quiet(60);
      check("timeout_arvalid_low", 64'(arvalid), 0);
      ar_addr_q.delete();
      ar_lat = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
